// File: rtl/axis_flit_serializer_credit.sv
// AXI-Stream beat to NoC flit serializer with credit-based flow control.
// Holds one beat; the next beat is accepted alongside the current beat's last flit.
module axis_flit_serializer_credit #(
   parameter int TDATA_WIDTH          = 512,
   parameter int TDEST_WIDTH          = 6,
   parameter int TUSER_WIDTH          = 32,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int FLIT_BUFFER_DEPTH    = 4,
   parameter int ENABLE_TKEEP_TRIM    = 1,
   localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR,
   localparam int KEEP_WIDTH = TDATA_WIDTH / 8,
   localparam int CW         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   axis_tvalid,
   output logic                   axis_tready,
   input  logic [TDATA_WIDTH-1:0] axis_tdata,
   input  logic [KEEP_WIDTH-1:0]  axis_tkeep,
   input  logic                   axis_tlast,
   input  logic [TUSER_WIDTH-1:0] axis_tuser,
   input  logic [TDEST_WIDTH-1:0] axis_tdest,
   output logic [FLIT_WIDTH-1:0]  data_out,
   output logic [TDEST_WIDTH-1:0] dest_out,
   output logic [TUSER_WIDTH-1:0] user_out,
   output logic                   is_tail_out,
   output logic                   send_out,
   input  logic                   credit_in,
   output logic [CW-1:0]          credit_count,
   output logic                   credit_overflow
);
   localparam int SF  = SERIALIZATION_FACTOR;
   localparam int SB  = KEEP_WIDTH / SF;
   localparam int NW  = $clog2(SF + 1);
   localparam int IW  = (SF > 1) ? $clog2(SF) : 1;
   localparam logic [CW-1:0] MAX_CREDIT = CW'(FLIT_BUFFER_DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   typedef struct packed {
      logic [SF-1:0][FLIT_WIDTH-1:0] data;
      logic [TDEST_WIDTH-1:0]        dest;
      logic [TUSER_WIDTH-1:0]        user;
      logic                          last;
      logic [NW-1:0]                 nflits;
   } beat_t;

   state_t        state, state_nxt;
   beat_t         hold;
   logic [NW-1:0] idx;
   logic [NW-1:0] trim_n, nflits_in;
   logic          credit_ok, last_flit, send_now, accept;

   assign credit_ok   = (credit_count != '0);
   assign last_flit   = (idx == hold.nflits - NW'(1));
   assign send_now    = (state == SEND) & credit_ok;
   assign axis_tready = rst_n & ((state == IDLE) | (send_now & last_flit));
   assign accept      = axis_tvalid & axis_tready;

   // Highest slice with any live byte sets the flit count; all-zero keep still sends slice 0.
   always_comb begin
      trim_n = NW'(1);
      for (int s = 0; s < SF; s++)
         if (|axis_tkeep[s*SB +: SB]) trim_n = NW'(s + 1);
   end
   assign nflits_in = (ENABLE_TKEEP_TRIM != 0) ? trim_n : NW'(SF);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = SEND;
         SEND: if (send_now && last_flit) state_nxt = accept ? SEND : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold        <= '0;
         idx         <= '0;
         send_out    <= 1'b0;
         is_tail_out <= 1'b0;
         data_out    <= '0;
         dest_out    <= '0;
         user_out    <= '0;
      end else begin
         send_out    <= send_now;
         is_tail_out <= send_now & last_flit & hold.last;
         if (send_now) begin
            data_out <= hold.data[idx[IW-1:0]];
            dest_out <= hold.dest;
            user_out <= hold.user;
         end
         if (accept) begin
            hold.data   <= axis_tdata;
            hold.dest   <= axis_tdest;
            hold.user   <= axis_tuser;
            hold.last   <= axis_tlast;
            hold.nflits <= nflits_in;
            idx         <= '0;
         end else if (send_now) begin
            idx <= idx + NW'(1);
         end
      end
   end

   // A send and a returned credit in the same cycle cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_count    <= MAX_CREDIT;
         credit_overflow <= 1'b0;
      end else if (credit_in && !send_now) begin
         if (credit_count == MAX_CREDIT) credit_overflow <= 1'b1;
         else                            credit_count    <= credit_count + CW'(1);
      end else if (send_now && !credit_in) begin
         credit_count <= credit_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_axis_flit_serializer_credit.sv
// Directed bench for the flit serializer: 64-bit beats, 4 x 16-bit flits, 4 credits.
module tb_axis_flit_serializer_credit;
   localparam int TDW = 64, TDEST = 6, TUSER = 8, SF = 4, DEPTH = 4;
   localparam int FW = TDW / SF, KW = TDW / 8, CW = $clog2(DEPTH + 1);

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             axis_tvalid = 1'b0, axis_tready;
   logic [TDW-1:0]   axis_tdata = '0;
   logic [KW-1:0]    axis_tkeep = '0;
   logic             axis_tlast = 1'b0;
   logic [TUSER-1:0] axis_tuser = '0;
   logic [TDEST-1:0] axis_tdest = '0;
   logic [FW-1:0]    data_out;
   logic [TDEST-1:0] dest_out;
   logic [TUSER-1:0] user_out;
   logic             is_tail_out, send_out, credit_in = 1'b0, credit_overflow;
   logic [CW-1:0]    credit_count;

   int checks = 0, failures = 0;

   axis_flit_serializer_credit #(
      .TDATA_WIDTH(TDW), .TDEST_WIDTH(TDEST), .TUSER_WIDTH(TUSER),
      .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH), .ENABLE_TKEEP_TRIM(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
      .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast), .axis_tuser(axis_tuser),
      .axis_tdest(axis_tdest), .data_out(data_out), .dest_out(dest_out),
      .user_out(user_out), .is_tail_out(is_tail_out), .send_out(send_out),
      .credit_in(credit_in), .credit_count(credit_count), .credit_overflow(credit_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic give_credits(input int n);
      credit_in = 1'b1;
      repeat (n) step();
      credit_in = 1'b0;
   endtask

   task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l);
      axis_tvalid = 1'b1;
      axis_tdata  = d;
      axis_tkeep  = k;
      axis_tlast  = l;
      axis_tdest  = 6'h2A;
      axis_tuser  = 8'h5C;
   endtask

   // Sends one beat and checks its n flits; starting credit c0 must be >= n.
   task automatic run_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                           input logic l, input int n, input int c0);
      int w = 0;
      while (!axis_tready && w < 20) begin step(); w++; end
      chk({tag, "_rdy"}, axis_tready, 1);
      drive(d, k, l);
      step();
      axis_tvalid = 1'b0;
      chk({tag, "_lat"}, send_out, 0);
      for (int i = 0; i < n; i++) begin
         step();
         chk({tag, "_send"}, send_out, 1);
         chk({tag, "_data"}, data_out, d[16*i +: 16]);
         chk({tag, "_tail"}, is_tail_out, (l && i == n - 1));
         chk({tag, "_dest"}, dest_out, 6'h2A);
         chk({tag, "_user"}, user_out, 8'h5C);
         chk({tag, "_cred"}, credit_count, c0 - i - 1);
      end
      step();
      chk({tag, "_done"}, send_out, 0);
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_tready", axis_tready, 0);
      chk("rst_send", send_out, 0);
      chk("rst_tail", is_tail_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_cred", credit_count, 4);
      chk("rst_ovf", credit_overflow, 0);
      rst_n = 1'b1;
      step();
      chk("idle_tready", axis_tready, 1);

      // Full beat, all slices live
      run_beat("full", 64'h4444_3333_2222_1111, 8'hFF, 1'b1, 4, 4);
      chk("full_cred0", credit_count, 0);
      give_credits(4);
      chk("full_cred4", credit_count, 4);

      // Trimming: slice 0 only, all-zero keep, slice 2 highest
      run_beat("trim1", 64'hDEAD_BEEF_CAFE_0A0A, 8'h03, 1'b1, 1, 4);
      give_credits(1);
      run_beat("trim0", 64'h0102_0304_0506_0B0B, 8'h00, 1'b0, 1, 4);
      give_credits(1);
      run_beat("trim3", 64'hFFFF_0C0C_0D0D_0E0E, 8'h30, 1'b1, 3, 4);
      give_credits(3);
      chk("trim_cred", credit_count, 4);

      // Back-to-back beats with a credit returned every flit cycle
      begin
         logic [63:0] b1, b2, exp;
         b1 = 64'h4444_3333_2222_1111;
         b2 = 64'h8888_7777_6666_5555;
         drive(b1, 8'hFF, 1'b0);
         step();
         drive(b2, 8'hFF, 1'b1);
         credit_in = 1'b1;
         for (int i = 0; i < 8; i++) begin
            chk("b2b_tready", axis_tready, (i == 3 || i == 7));
            step();
            if (i == 3) axis_tvalid = 1'b0;
            exp = (i < 4) ? b1 : b2;
            chk("b2b_send", send_out, 1);
            chk("b2b_data", data_out, exp[16*(i%4) +: 16]);
            chk("b2b_tail", is_tail_out, (i == 7));
            chk("b2b_cred", credit_count, 4);
         end
         credit_in = 1'b0;
         step();
         chk("b2b_end", send_out, 0);
         chk("b2b_idle", axis_tready, 1);
      end

      // Credit stall: drain to 2 credits, then a 4-flit beat runs dry
      run_beat("pre", 64'h0000_0000_BBBB_AAAA, 8'h0C, 1'b0, 2, 4);
      drive(64'hD4D4_C3C3_B2B2_A1A1, 8'hFF, 1'b1);
      step();
      axis_tvalid = 1'b0;
      step();
      chk("stall_f0", data_out, 16'hA1A1);
      step();
      chk("stall_f1", data_out, 16'hB2B2);
      chk("stall_cred0", credit_count, 0);
      step();
      chk("stall_send", send_out, 0);
      chk("stall_tready", axis_tready, 0);
      step();
      chk("stall_hold", data_out, 16'hB2B2);
      give_credits(1);
      chk("stall_wait", send_out, 0);
      step();
      chk("stall_f2_send", send_out, 1);
      chk("stall_f2", data_out, 16'hC3C3);
      chk("stall_f2_tail", is_tail_out, 0);
      step();
      chk("stall_one", send_out, 0);
      give_credits(1);
      step();
      chk("stall_f3", data_out, 16'hD4D4);
      chk("stall_f3_tail", is_tail_out, 1);
      give_credits(4);
      chk("stall_cred4", credit_count, 4);
      chk("no_ovf", credit_overflow, 0);

      // Credit return at full count saturates and latches overflow
      give_credits(1);
      chk("ovf_cred", credit_count, 4);
      chk("ovf_flag", credit_overflow, 1);
      step();
      chk("ovf_sticky", credit_overflow, 1);

      // Reset after flit 2 of 4
      drive(64'h4444_3333_2222_1111, 8'hFF, 1'b1);
      step();
      axis_tvalid = 1'b0;
      step();
      step();
      chk("mid_f1", data_out, 16'h2222);
      rst_n = 1'b0;
      #1;
      chk("mid_send", send_out, 0);
      chk("mid_data", data_out, 0);
      chk("mid_tail", is_tail_out, 0);
      chk("mid_cred", credit_count, 4);
      chk("mid_ovf", credit_overflow, 0);
      chk("mid_tready", axis_tready, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_quiet", send_out, 0);
      run_beat("post", 64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1, 4, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/axis_flit_serializer_credit.md
Name: axis_flit_serializer_credit

Overview:
- Single-clock AXI-Stream to NoC flit serializer with credit-based flow control, for router-side injection ports of the mesh.
- Accepts one wide AXIS beat and emits up to SERIALIZATION_FACTOR flits. Optional TKEEP trimming drops trailing empty flit slices.
- Holds one beat. A back-to-back path accepts the next beat in the same cycle as the current beat's last flit, so no bubble is inserted.
- A credit counter tracks free slots in the downstream router flit buffer.

Parameters:
- TDATA_WIDTH, 512, AXIS data width; must be a multiple of 8*SERIALIZATION_FACTOR.
- TDEST_WIDTH, 6, routing destination width (tid and tdest concatenated upstream).
- TUSER_WIDTH, 32, sideband width, replicated on every flit.
- SERIALIZATION_FACTOR, 4, flit slices per beat (>=1).
- FLIT_BUFFER_DEPTH, 4, downstream buffer depth; equals the initial and maximum credit count (>=1).
- ENABLE_TKEEP_TRIM, 1, 1 = send only live slices; 0 = always send SERIALIZATION_FACTOR flits.
- Derived: FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR; KEEP_WIDTH = TDATA_WIDTH/8; CW = $clog2(FLIT_BUFFER_DEPTH+1).

Ports:
- clk  in  1  the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- axis_tvalid  in  1  beat valid.
- axis_tready  out  1  beat ready.
- axis_tdata  in  TDATA_WIDTH  beat data; slice 0 = bits [FLIT_WIDTH-1:0].
- axis_tkeep  in  KEEP_WIDTH  byte enables.
- axis_tlast  in  1  last beat of packet.
- axis_tuser  in  TUSER_WIDTH  sideband.
- axis_tdest  in  TDEST_WIDTH  destination.
- data_out  out  FLIT_WIDTH  flit payload.
- dest_out  out  TDEST_WIDTH  flit destination.
- user_out  out  TUSER_WIDTH  flit sideband.
- is_tail_out  out  1  last flit of packet.
- send_out  out  1  flit valid; one pulse per flit.
- credit_in  in  1  one credit returned per cycle asserted.
- credit_count  out  CW  current credits.
- credit_overflow  out  1  sticky error flag.

Behaviour:
- Reset values:
  - State IDLE; axis_tready=0 while rst_n=0.
  - send_out=0, is_tail_out=0, data_out/dest_out/user_out=0.
  - credit_count=FLIT_BUFFER_DEPTH; credit_overflow=0.
- States:
  - IDLE: axis_tready=1. Handshake (tvalid&tready) captures tdata/tdest/tuser/tlast, sets num_flits, sets idx=0, moves to SEND.
  - SEND: on each cycle with credit_count>0, register slice[idx] to the outputs at the next edge with send_out=1, and increment idx. If credit_count==0, send_out=0 and all registers hold.
  - Leaving SEND: when idx==num_flits-1 and credit_count>0, the flit goes out. In that same cycle axis_tready=1. A new handshake reloads the holding register and stays in SEND; otherwise the state goes to IDLE.
- axis_tready = (state==IDLE) | (state==SEND & last flit & credit_count>0). It is combinational from registers only and does not depend on axis_tvalid.
- num_flits:
  - ENABLE_TKEEP_TRIM=0: SERIALIZATION_FACTOR.
  - ENABLE_TKEEP_TRIM=1: 1 + index of the highest slice whose tkeep bits have any 1.
  - All-zero tkeep sends 1 flit (slice 0).
- Latency: a beat accepted at edge t produces its first flit with send_out=1 after edge t+1 (credits permitting). Peak rate is one flit per cycle, sustained across beats.
- Per-flit fields:
  - dest_out and user_out equal the captured values on every flit.
  - is_tail_out=1 only on the last flit of a beat whose tlast=1.
- Credits:
  - Send only: credit_count decrements.
  - credit_in only: credit_count increments.
  - Both in the same cycle: no change.
  - credit_in at FLIT_BUFFER_DEPTH with no send: count saturates and credit_overflow sets, held until reset.
  - credit_count never underflows; a send is only issued when credit_count>0.
- Reset mid-beat: the partially sent beat is discarded with no tail emitted, and the credit count is restored to FLIT_BUFFER_DEPTH.

Test Plan:
- SF=4, TRIM=0, credits=4: one beat, tlast=1, data slices A,B,C,D -> send_out pulses on 4 consecutive cycles, first one cycle after accept; data A,B,C,D; is_tail_out only on D; credit_count 4->0.
- TRIM=1: tkeep=0x0000_..._FFFF (slice 0 only), then tkeep=0 -> each beat emits exactly 1 flit; tkeep with slice 2 as highest live slice -> 3 flits.
- Two beats back-to-back, 8 credits, credit_in returned each cycle -> 8 flits on 8 consecutive cycles, axis_tready high on the 4th flit cycle, no bubble.
- FLIT_BUFFER_DEPTH=2, no credit_in -> 2 flits, then send_out=0 and axis_tready=0; one credit_in pulse -> exactly one more flit one cycle later.
- credit_in and send in the same cycle -> count unchanged; credit_in at count=4 while idle -> count stays 4, credit_overflow=1 until rst_n low.
- rst_n low after flit 2 of 4 -> outputs 0 asynchronously, count=4; after release, the next beat starts at slice 0.
